mp3_ctrl_panel: RTL and testbench

Front-panel control stage directly upstream of the MP3 decoder SPI controller. It debounces four push-buttons: volume up, volume down, next song and pause. From them it produces the registered control levels the decoder controller consumes:
- 16-bit SCI_VOL word (left/right attenuation bytes)
- song-select toggle level and song index
- pause level
All outputs are held stable between accepted presses, so the downstream controller's change-detection logic sees exactly one change per press.

---
 rtl/mp3_pkg.sv | 38 +++
 rtl/mp3_ctrl_panel_btn_debounce.sv | 51 +++++
 rtl/mp3_ctrl_panel.sv | 143 ++++++++++++++
 tb/tb_mp3_ctrl_panel.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// mp3_pkg : shared types, button bit indices and SCI_VOL helpers
// Revision: 1.0
// ============================================================================
package mp3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int N_BTN      = 4;
  localparam int BIT_VOL_UP = 0;
  localparam int BIT_VOL_DN = 1;
  localparam int BIT_NEXT   = 2;
  localparam int BIT_PAUSE  = 3;

  localparam logic [7:0] VOL_LOUDEST = 8'h00;
  localparam logic [7:0] VOL_SILENT  = 8'hFE;

  function automatic logic [7:0] att_louder(input logic [7:0] att,
                                            input logic [7:0] step);
    return (att < step) ? VOL_LOUDEST : att - step;
  endfunction

  // 9-bit sum so the carry out of the byte is seen as saturation
  function automatic logic [7:0] att_quieter(input logic [7:0] att,
                                             input logic [7:0] step,
                                             input logic [7:0] max_att);
    logic [8:0] sum;
    sum = {1'b0, att} + {1'b0, step};
    return (sum > {1'b0, max_att}) ? max_att : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp3_ctrl_panel_btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-flop synchroniser, stable-count debouncer, press pulse
// Revision: 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_dly_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/mp3_ctrl_panel.sv
`default_nettype none
// ============================================================================
// mp3_ctrl_panel : debounced front panel -> SCI_VOL / song / pause levels
// Optional volume auto-repeat: define VOL_AUTO_REPEAT_EN.   Revision: 1.0
// ============================================================================
module mp3_ctrl_panel
  import mp3_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [7:0]  VOL_STEP        = 8'h10,
  parameter logic [15:0] VOL_INIT        = 16'h2020,
  parameter logic [7:0]  VOL_MAX_ATT     = VOL_SILENT,
  parameter int          SONG_NUM        = 4,
  parameter int          REPEAT_CYCLES   = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_vol_up,
  input  logic        i_btn_vol_dn,
  input  logic        i_btn_next,
  input  logic        i_btn_pause,
  input  logic        i_finish,
  output logic [15:0] o_vol,
  output logic        o_song_toggle,
  output logic [1:0]  o_song_idx,
  output logic        o_pause,
  output logic        o_busy
);

`ifdef VOL_AUTO_REPEAT_EN
  localparam logic RPT_EN = 1'b1;
`else
  localparam logic RPT_EN = 1'b0;
`endif
  localparam int              RW       = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0]   RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [N_BTN-1:0] VOL_MASK = N_BTN'((1 << BIT_VOL_UP) | (1 << BIT_VOL_DN));

  logic [N_BTN-1:0] raw, level, press;

  assign raw[BIT_VOL_UP] = i_btn_vol_up;
  assign raw[BIT_VOL_DN] = i_btn_vol_dn;
  assign raw[BIT_NEXT]   = i_btn_next;
  assign raw[BIT_PAUSE]  = i_btn_pause;

  generate
    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (raw[b]),
        .level_o (level[b]),
        .press_o (press[b])
      );
    end
  endgenerate

  state_t           state_q, state_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [15:0]      vol_q, vol_d;
  logic [1:0]       idx_q, idx_d;
  logic             tog_q, tog_d, pause_q, pause_d, busy_q;
  logic [RW-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire;

  // Repeat timer runs only while exactly one volume button is held in HOLD
  always_comb begin
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (RPT_EN && state_q == ST_HOLD && (level[BIT_VOL_UP] ^ level[BIT_VOL_DN])) begin
      if (rpt_cnt_q == RPT_LAST) rpt_fire = 1'b1;
      else                       rpt_cnt_d = rpt_cnt_q + RW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | press;
    vol_d     = vol_q;
    idx_d     = idx_q;
    tog_d     = tog_q;
    pause_d   = pause_q;
    case (state_q)
      ST_IDLE: begin
        if (((pending_q | press) != '0) && !i_finish) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        pending_d = press;
        if (pending_q[BIT_VOL_UP] && !pending_q[BIT_VOL_DN]) begin
          vol_d = {att_louder(vol_q[15:8], VOL_STEP), att_louder(vol_q[7:0], VOL_STEP)};
        end else if (pending_q[BIT_VOL_DN] && !pending_q[BIT_VOL_UP]) begin
          vol_d = {att_quieter(vol_q[15:8], VOL_STEP, VOL_MAX_ATT),
                   att_quieter(vol_q[7:0],  VOL_STEP, VOL_MAX_ATT)};
        end
        if (pending_q[BIT_NEXT]) begin
          idx_d = (idx_q == 2'(SONG_NUM - 1)) ? 2'd0 : idx_q + 2'd1;
          tog_d = ~tog_q;
        end
        if (pending_q[BIT_PAUSE]) pause_d = ~pause_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (rpt_fire) begin
          pending_d = pending_q | press | (level & VOL_MASK);
          state_d   = ST_APPLY;
        end else if (level == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      vol_q     <= VOL_INIT;
      idx_q     <= 2'd0;
      tog_q     <= 1'b0;
      pause_q   <= 1'b0;
      busy_q    <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      vol_q     <= vol_d;
      idx_q     <= idx_d;
      tog_q     <= tog_d;
      pause_q   <= pause_d;
      busy_q    <= i_finish;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign o_vol         = vol_q;
  assign o_song_idx    = idx_q;
  assign o_song_toggle = tog_q;
  assign o_pause       = pause_q;
  assign o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mp3_ctrl_panel.sv
`default_nettype none
// ============================================================================
// tb_mp3_ctrl_panel : randomized + directed bench with cycle-timed reference
// Revision: 1.0
// ============================================================================
module tb_mp3_ctrl_panel;

  localparam int D   = 4;
  localparam int RPT = 16;
  localparam int LAT = D + 5;   // raw edge to visible output change

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, dn = 1'b0, nx = 1'b0, ps = 1'b0, fin = 1'b0;
  logic [15:0] o_vol;
  logic        o_song_toggle, o_pause, o_busy;
  logic [1:0]  o_song_idx;

  always #5 clk = ~clk;

  mp3_ctrl_panel #(
    .DEBOUNCE_CYCLES(D), .VOL_STEP(8'h10), .VOL_INIT(16'h2020),
    .VOL_MAX_ATT(8'hFE), .SONG_NUM(4), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_btn_vol_up(up), .i_btn_vol_dn(dn), .i_btn_next(nx), .i_btn_pause(ps),
    .i_finish(fin),
    .o_vol(o_vol), .o_song_toggle(o_song_toggle), .o_song_idx(o_song_idx),
    .o_pause(o_pause), .o_busy(o_busy)
  );

  typedef struct { int att; int idx; int tog; int pau; } mstate_t;
  typedef struct { int eff; mstate_t st; } event_t;

  event_t  evq[$];
  mstate_t cur;
  int      cyc = 0;
  int      fin_at_edge = 0;
  int      total = 0;
  int      bad = 0;
  bit      chk_en = 1'b0;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.att = 32; s.idx = 0; s.tog = 0; s.pau = 0;
    return s;
  endfunction

  function automatic mstate_t predict(mstate_t s, bit u, bit d, bit n, bit p);
    mstate_t r = s;
    if (u && !d) r.att = (s.att < 16) ? 0 : s.att - 16;
    if (d && !u) r.att = (s.att + 16 > 254) ? 254 : s.att + 16;
    if (n) begin r.idx = (s.idx + 1) % 4; r.tog = 1 - s.tog; end
    if (p) r.pau = 1 - s.pau;
    return r;
  endfunction

  function automatic mstate_t last_pred();
    return (evq.size() > 0) ? evq[$].st : cur;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input mstate_t s, input int eff);
    event_t e;
    e.eff = eff; e.st = s;
    evq.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      evq.delete();
      cur = reset_state();
      fin_at_edge = 0;
    end else begin
      fin_at_edge = fin;
    end
  end

  always @(negedge clk) begin
    while (evq.size() > 0 && evq[0].eff <= cyc) cur = evq.pop_front().st;
    if (chk_en) begin
      check("vol",    o_vol,         cur.att * 257);
      check("idx",    o_song_idx,    cur.idx);
      check("toggle", o_song_toggle, cur.tog);
      check("pause",  o_pause,       cur.pau);
      check("busy",   o_busy,        fin_at_edge);
    end
  end

  task automatic drive(input bit u, input bit d, input bit n, input bit p);
    up = u; dn = d; nx = n; ps = p;
  endtask

  task automatic press(input bit u, input bit d, input bit n, input bit p,
                       input int hold, input int rel, input bit glitch, input bit defer);
    if (glitch) begin
      @(posedge clk); #1; drive(u, d, n, p);
      repeat (2) @(posedge clk);
      #1; drive(0, 0, 0, 0);
      @(posedge clk);
    end
    @(posedge clk); #1; drive(u, d, n, p);
    if (!defer) push(predict(last_pred(), u, d, n, p), cyc + LAT);
    repeat (hold) @(posedge clk);
    #1; drive(0, 0, 0, 0);
    repeat (rel) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; drive(0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = reset_state();
    @(posedge clk); #1; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_vol", o_vol, 16'h2020);
    check("rst_idx", o_song_idx, 0);
    check("rst_tog", o_song_toggle, 0);
    check("rst_pause", o_pause, 0);
    check("rst_busy", o_busy, 0);

    // glitch then stable press, and saturation towards loudest
    press(1, 0, 0, 0, 10, 10, 1, 0);
    check("vol_up1", o_vol, 16'h1010);
    press(1, 0, 0, 0, 10, 10, 0, 0);
    check("vol_up2", o_vol, 16'h0000);
    press(1, 0, 0, 0, 10, 10, 0, 0);
    check("vol_up3", o_vol, 16'h0000);

    // saturation towards quietest, then simultaneous up+down
    do_reset();
    for (int i = 0; i < 16; i++) press(0, 1, 0, 0, 8, 10, 0, 0);
    check("vol_sat", o_vol, 16'hFEFE);
    press(1, 1, 0, 0, 10, 10, 0, 0);
    check("vol_updn", o_vol, 16'hFEFE);

    // song wrap
    for (int i = 0; i < 4; i++) begin
      press(0, 0, 1, 0, 10, 10, 0, 0);
      check("song_idx", o_song_idx, (i + 1) % 4);
      check("song_tog", o_song_toggle, (i + 1) % 2);
    end

    // long hold on volume down
    do_reset();
`ifdef VOL_AUTO_REPEAT_EN
    chk_en = 1'b0;
    press(0, 1, 0, 0, 100, 10, 0, 1);
    check("auto_repeat", (o_vol > 16'h4040 && o_vol[15:8] == o_vol[7:0]) ? 1 : 0, 1);
    do_reset();
    chk_en = 1'b1;
`else
    press(0, 1, 0, 0, 100, 10, 0, 0);
    check("hold_one_step", o_vol, 16'h3030);
`endif

    // pause deferred while the decoder restarts
    @(posedge clk); #1; fin = 1'b1;
    press(0, 0, 0, 1, 10, 10, 0, 1);
    @(negedge clk);
    check("pause_deferred", o_pause, 0);
    check("busy_high", o_busy, 1);
    @(posedge clk); #1; fin = 1'b0;
    push(predict(last_pred(), 0, 0, 0, 1), cyc + 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pause_applied", o_pause, 1);
    repeat (10) @(posedge clk);

    // reset landing on the APPLY cycle
    @(posedge clk); #1; drive(0, 0, 1, 0);
    push(predict(last_pred(), 0, 0, 1, 0), cyc + LAT);
    repeat (LAT - 1) @(posedge clk);
    #1; rst = 1'b1; drive(0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_apply_idx", o_song_idx, 0);
    check("rst_apply_pause", o_pause, 0);
    check("rst_apply_vol", o_vol, 16'h2020);

    // randomized presses, possibly several buttons at once
    repeat (10) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      int m;
      m = $urandom_range(1, 15);
      press(m[0], m[1], m[2], m[3], $urandom_range(8, 12), $urandom_range(10, 16), $urandom_range(0, 1), 0);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
